// File: rtl/enclock_tx.sv
`default_nettype none
// ============================================================================
// Module   : enclock_tx
// Brief    : Clock-embedding pulse-width encoder (sync pair + DATA_W payload).
// Revision : 1.0 - initial release
// ============================================================================
module enclock_tx #(
   parameter int MIN_HALF  = 101,
   parameter int LONG_MULT = 3,
   parameter int DATA_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [15:0]       half_period,
   input  logic [DATA_W-1:0] data,
   output logic              code,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int BW = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SYNC_L = 3'd1,
      S_GAP0   = 3'd2,
      S_SYNC_S = 3'd3,
      S_GAP1   = 3'd4,
      S_BIT_HI = 3'd5,
      S_BIT_LO = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   state_t            state_q, state_d;
   logic [18:0]       cnt_q, cnt_d;
   logic [15:0]       half_q, half_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     bits_q, bits_d;
   logic              code_q, code_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [18:0]       long_in;
   logic [18:0]       half_w;
   logic [DATA_W-1:0] shift_nxt;

   // 19 bits holds 7*65535, so the legality product never overflows
   assign long_in   = 19'(LONG_MULT) * {3'b000, half_period};
   assign half_w    = {3'b000, half_q};
   assign shift_nxt = shift_q << 1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      half_d  = half_q;
      shift_d = shift_q;
      bits_d  = bits_q;
      err_d   = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               if ((half_period < 16'(MIN_HALF)) || (long_in > 19'd65535)) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_SYNC_L;
                  cnt_d   = long_in - 19'd1;
                  half_d  = half_period;
                  shift_d = data;
                  bits_d  = BW'(DATA_W);
               end
            end
         end
         default: begin
            if (cnt_q != 19'd0) begin
               cnt_d = cnt_q - 19'd1;
            end else begin
               case (state_q)
                  S_SYNC_L: begin
                     state_d = S_GAP0;
                     cnt_d   = half_w - 19'd1;
                  end
                  S_GAP0: begin
                     state_d = S_SYNC_S;
                     cnt_d   = half_w - 19'd1;
                  end
                  S_SYNC_S: begin
                     state_d = S_GAP1;
                     cnt_d   = half_w - 19'd1;
                  end
                  S_GAP1: begin
                     state_d = S_BIT_HI;
                     cnt_d   = shift_q[DATA_W-1] ? (half_w + half_w - 19'd1) : (half_w - 19'd1);
                  end
                  S_BIT_HI: begin
                     state_d = S_BIT_LO;
                     cnt_d   = half_w - 19'd1;
                  end
                  S_BIT_LO: begin
                     shift_d = shift_nxt;
                     bits_d  = bits_q - BW'(1);
                     if (bits_q == BW'(1)) begin
                        state_d = S_DONE;
                     end else begin
                        // The next bit's width comes from the post-shift MSB
                        state_d = S_BIT_HI;
                        cnt_d   = shift_nxt[DATA_W-1] ? (half_w + half_w - 19'd1) : (half_w - 19'd1);
                     end
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
      endcase

      // Outputs are registered from the next state so they align with it
      code_d = (state_d == S_SYNC_L) || (state_d == S_SYNC_S) || (state_d == S_BIT_HI);
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         half_q  <= '0;
         shift_q <= '0;
         bits_q  <= '0;
         code_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         shift_q <= shift_d;
         bits_q  <= bits_d;
         code_q  <= code_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign code = code_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_enclock_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_enclock_tx
// Brief    : Directed/randomized bench; reference frames built as level/length runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enclock_tx;

   localparam int MIN_HALF  = 101;
   localparam int LONG_MULT = 3;
   localparam int DATA_W    = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [15:0]       half_period = '0;
   logic [DATA_W-1:0] data = '0;
   logic              code, busy, done, err;

   int n_vec = 0;
   int n_err = 0;

   int obs_len[$];
   bit obs_lvl[$];
   int last_gap;

   always #5 clk = ~clk;

   enclock_tx #(
      .MIN_HALF  (MIN_HALF),
      .LONG_MULT (LONG_MULT),
      .DATA_W    (DATA_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .half_period (half_period),
      .data        (data),
      .code        (code),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Request a frame; returns just after the acceptance edge (sample k=0)
   task automatic begin_frame(input int h, input logic [DATA_W-1:0] d, input bit hold);
      @(negedge clk);
      start       = 1'b1;
      half_period = 16'(h);
      data        = d;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   // Record the code line as runs until done, then compare against the frame
   // the rules describe. Inputs are scrambled throughout to prove they are latched.
   task automatic capture(input int h, input logic [DATA_W-1:0] d, input string tag);
      int exp_len[$];
      bit exp_lvl[$];
      int total, k, busy_cnt, err_cnt, n;
      logic [DATA_W-1:0] dec;

      exp_len = {LONG_MULT * h, h, h, h};
      exp_lvl = {1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = DATA_W - 1; i >= 0; i--) begin
         exp_lvl.push_back(1'b1); exp_len.push_back(d[i] ? 2 * h : h);
         exp_lvl.push_back(1'b0); exp_len.push_back(h);
      end
      total = 0;
      foreach (exp_len[i]) total += exp_len[i];

      obs_len.delete(); obs_lvl.delete();
      k = 0; busy_cnt = 0; err_cnt = 0;
      while (done !== 1'b1 && k <= total + 16) begin
         if (k == 0 || code !== obs_lvl[$]) begin
            obs_lvl.push_back(code === 1'b1);
            obs_len.push_back(1);
         end else begin
            obs_len[$] = obs_len[$] + 1;
         end
         busy_cnt += (busy === 1'b1) ? 1 : 0;
         err_cnt  += (err === 1'b1) ? 1 : 0;
         half_period = 16'($urandom);
         data        = DATA_W'($urandom);
         @(posedge clk);
         #1;
         k++;
      end

      check({tag, "/done_cycle"}, k, total);
      check({tag, "/busy_cycles"}, busy_cnt, total);
      check({tag, "/busy_at_done"}, busy, 0);
      check({tag, "/code_at_done"}, code, 0);
      check({tag, "/err_in_frame"}, err_cnt, 0);
      check({tag, "/run_count"}, obs_len.size(), exp_len.size());
      n = (obs_len.size() < exp_len.size()) ? obs_len.size() : exp_len.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s/run%0d(lvl*1e6+len)", tag, i),
               obs_lvl[i] * 1000000 + obs_len[i], exp_lvl[i] * 1000000 + exp_len[i]);

      // Far-end view: declk from the short sync pulse, bits decoded by width
      dec = '0;
      if (obs_len.size() > 2) begin
         check({tag, "/declk"}, obs_len[2], h);
         for (int i = 0; i < DATA_W; i++) begin
            int idx = 4 + 2 * i;
            bit b = (idx < obs_len.size()) && (obs_len[idx] > obs_len[2] + obs_len[2] / 2);
            dec = {dec[DATA_W-2:0], b};
         end
      end
      check({tag, "/decoded_data"}, dec, d);
      last_gap = (obs_lvl.size() > 0 && !obs_lvl[$]) ? obs_len[$] + 1 : -1;
   endtask

   initial begin
      int g1, dcnt, h;
      logic [DATA_W-1:0] d1, d2;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset/code", code, 0);
      check("reset/busy", busy, 0);
      check("reset/done", done, 0);
      check("reset/err",  err,  0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic frame, all-zero payload at minimum H
      begin_frame(101, 16'h0000, 1'b0);
      capture(101, 16'h0000, "basic");

      // Mixed payload
      begin_frame(200, 16'hA5A5, 1'b0);
      capture(200, 16'hA5A5, "a5a5");

      // Rejects and the legal boundary just below the product limit
      begin_frame(100, 16'h1234, 1'b0);
      check("rej100/err",  err,  1);
      check("rej100/busy", busy, 0);
      check("rej100/code", code, 0);
      @(posedge clk); #1;
      check("rej100/err_one_cycle", err, 0);
      check("rej100/busy_after", busy, 0);

      begin_frame(21846, 16'h1234, 1'b0);
      check("rej21846/err",  err,  1);
      check("rej21846/busy", busy, 0);

      begin_frame(21845, 16'h1234, 1'b0);
      check("ok21845/err",  err,  0);
      check("ok21845/busy", busy, 1);
      check("ok21845/code", code, 1);
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort21845/code", code, 0);
      check("abort21845/busy", busy, 0);
      @(negedge clk); rst_n = 1'b1;

      // Back-to-back with start held high
      d1 = DATA_W'($urandom);
      d2 = DATA_W'($urandom);
      begin_frame(150, d1, 1'b1);
      capture(150, d1, "b2b1");
      g1 = last_gap;
      half_period = 16'd150;
      data        = d2;
      @(posedge clk); #1;
      capture(150, d2, "b2b2");
      start = 1'b0;
      check("b2b/low_between_frames", g1, 151);
      @(posedge clk); #1;
      check("b2b/idle_after_busy", busy, 0);
      check("b2b/idle_after_code", code, 0);

      // Reset inside SYNC_S at cycle 500 of a frame
      begin_frame(101, DATA_W'($urandom), 1'b0);
      repeat (500) begin @(posedge clk); #1; end
      check("midrst/code_in_sync_s", code, 1);
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst/code", code, 0);
      check("midrst/busy", busy, 0);
      check("midrst/done", done, 0);
      @(negedge clk); rst_n = 1'b1;
      dcnt = 0;
      repeat (300) begin @(posedge clk); #1; dcnt += (done === 1'b1 || busy === 1'b1) ? 1 : 0; end
      check("midrst/no_done_or_busy_after", dcnt, 0);
      d1 = DATA_W'($urandom);
      begin_frame(101, d1, 1'b0);
      capture(101, d1, "postrst");

      // Loopback view at H=120: recovered clock period is one 0-bit (high+low)
      d1 = 16'h0F0F;
      begin_frame(120, d1, 1'b0);
      capture(120, d1, "loop120");
      if (obs_len.size() > 9)
         check("loop120/recovered_period", obs_len[8] + obs_len[9], 240);

      // Randomized frames
      for (int r = 0; r < 3; r++) begin
         h  = $urandom_range(101, 160);
         d1 = DATA_W'($urandom);
         begin_frame(h, d1, 1'b0);
         capture(h, d1, $sformatf("rand%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
